// File: rtl/sim_state_trace_recorder_if.sv
// Purpose: bundles the recorder's sample inputs, control strobes and trace-sink handshake.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready on the sink side; sample side has no backpressure.
// Optional: TRACE_STATS_EN adds stat_sel/stat_count.
interface sim_state_trace_recorder_if #(
  parameter int MAX_CYCLE_WIDTH = 5,
  parameter int DEPTH           = 8,
  parameter int DROP_WIDTH      = 8
);
  logic [1:0]                 state;
  logic [MAX_CYCLE_WIDTH-1:0] current_cycle;
  logic                       enable;
  logic                       clear;
  logic                       out_valid;
  logic                       out_ready;
  logic [1:0]                 out_state;
  logic [MAX_CYCLE_WIDTH-1:0] out_cycle;
  logic                       out_wrap;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic [DROP_WIDTH-1:0]      drop_count;
`ifdef TRACE_STATS_EN
  logic [1:0]                 stat_sel;
  logic [15:0]                stat_count;
`endif

  // Driver side: simulator/testbench feeding samples and consuming records.
  modport master (
    output state, current_cycle, enable, clear, out_ready,
`ifdef TRACE_STATS_EN
    output stat_sel,
    input  stat_count,
`endif
    input  out_valid, out_state, out_cycle, out_wrap, count, overflow, drop_count
  );

  // Recorder side.
  modport slave (
    input  state, current_cycle, enable, clear, out_ready,
`ifdef TRACE_STATS_EN
    input  stat_sel,
    output stat_count,
`endif
    output out_valid, out_state, out_cycle, out_wrap, count, overflow, drop_count
  );
endinterface

// File: rtl/sim_state_trace_recorder.sv
// Purpose: records every change of the 2-bit simulator state as {state, cycle, wrap} into a FIFO.
// Latency: an event in cycle k is visible at the head from cycle k+1 (no bypass).
// Backpressure: holds the head while out_ready=0; events hitting a full FIFO without a pop are
// dropped and counted.
// Optional: TRACE_STATS_EN adds per-state 16-bit saturating occupancy counters.
module sim_state_trace_recorder #(
  parameter int MAX_CYCLE_WIDTH = 5,
  parameter int DEPTH           = 8,
  parameter int DROP_WIDTH      = 8
) (
  input logic clk,
  input logic reset,
  sim_state_trace_recorder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  logic [1:0]                 r_mem_state [DEPTH];
  logic [MAX_CYCLE_WIDTH-1:0] r_mem_cycle [DEPTH];
  logic                       r_mem_wrap  [DEPTH];
  logic [PW-1:0]              r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_overflow;
  logic [DROP_WIDTH-1:0]      r_drop_count;
  logic [1:0]                 r_prev_state;
  logic [MAX_CYCLE_WIDTH-1:0] r_prev_cycle;
  logic                       r_primed;
  logic                       r_wrap_pend;

  logic w_valid, w_full, w_pop, w_event, w_wrap_now, w_push, w_drop, w_rec_wrap;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == LP_FULL);
  // clear wins over everything: no pop, no event, no write in that cycle.
  assign w_pop      = w_valid && bus.out_ready && !bus.clear;
  assign w_event    = bus.enable && !bus.clear && (!r_primed || (bus.state != r_prev_state));
  assign w_wrap_now = bus.enable && !bus.clear && r_primed && (bus.current_cycle < r_prev_cycle);
  // A full FIFO that pops in the same cycle still has room for the new tail.
  assign w_push     = w_event && (!w_full || w_pop);
  assign w_drop     = w_event && w_full && !w_pop;
  // A wrap seen in the event cycle itself belongs to that record.
  assign w_rec_wrap = r_wrap_pend || w_wrap_now;

  // Sample tracking: previous state/cycle, primed flag and pending wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_state <= '0;
      r_prev_cycle <= '0;
      r_primed     <= 1'b0;
      r_wrap_pend  <= 1'b0;
    end else if (bus.clear) begin
      r_primed     <= 1'b0;
      r_wrap_pend  <= 1'b0;
    end else begin
      if (bus.enable) begin
        r_prev_state <= bus.state;
        r_prev_cycle <= bus.current_cycle;
        r_primed     <= 1'b1;
      end
      // Only an actual write consumes the pending wrap; a dropped record leaves it pending.
      if (w_push) begin
        r_wrap_pend <= 1'b0;
      end else if (w_wrap_now) begin
        r_wrap_pend <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and overflow accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (bus.clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (!(&r_drop_count)) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  // Record storage; contents are don't-care until written, outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_state[r_wr_ptr] <= bus.state;
      r_mem_cycle[r_wr_ptr] <= bus.current_cycle;
      r_mem_wrap[r_wr_ptr]  <= w_rec_wrap;
    end
  end

  assign bus.out_valid  = w_valid;
  assign bus.out_state  = w_valid ? r_mem_state[r_rd_ptr] : 2'b00;
  assign bus.out_cycle  = w_valid ? r_mem_cycle[r_rd_ptr] : '0;
  assign bus.out_wrap   = w_valid ? r_mem_wrap[r_rd_ptr]  : 1'b0;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;

`ifdef TRACE_STATS_EN
  logic [15:0] r_stat [4];

  // Per-state residency counters: one increment per enabled cycle, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= '0;
    end else if (bus.enable && !(&r_stat[bus.state])) begin
      r_stat[bus.state] <= r_stat[bus.state] + 1'b1;
    end
  end

  assign bus.stat_count = r_stat[bus.stat_sel];
`endif
endmodule
